// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the MIPS pipeline registers: control-vector bit
// positions, ID/EX payload field offsets and the legal register depth range.
package cpu_pipe_pkg;

    localparam int MIN_DEPTH = 1;
    localparam int MAX_DEPTH = 4;

    // Control vector bit positions
    localparam int CTRL_REGDST    = 0;
    localparam int CTRL_ALUSRC    = 1;
    localparam int CTRL_MEMTOREG  = 2;
    localparam int CTRL_REGWRITE  = 3;
    localparam int CTRL_MEMREAD   = 4;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_BJ_LSB    = 6;
    localparam int CTRL_BJ_W      = 3;
    localparam int CTRL_ALUOP_LSB = 9;
    localparam int CTRL_ALUOP_W   = 5;

    // Base ID/EX packing (128 bits): PC+4 | RD1 | RD2 | OFFSET, MSB first
    localparam int IDEX_W          = 128;
    localparam int IDEX_PC_LSB     = 96;
    localparam int IDEX_RD1_LSB    = 64;
    localparam int IDEX_RD2_LSB    = 32;
    localparam int IDEX_OFFSET_LSB = 0;
    localparam int IDEX_WORD_W     = 32;

    // Extended ID/EX packing: the four words above, then Rs | Rt | Rd | funct
    localparam int IDEX_X_W          = 149;
    localparam int IDEX_X_PC_LSB     = 117;
    localparam int IDEX_X_RD1_LSB    = 85;
    localparam int IDEX_X_RD2_LSB    = 53;
    localparam int IDEX_X_OFFSET_LSB = 21;
    localparam int IDEX_X_RS_LSB     = 16;
    localparam int IDEX_X_RT_LSB     = 11;
    localparam int IDEX_X_RD_LSB     = 6;
    localparam int IDEX_X_FUNCT_LSB  = 0;
    localparam int REG_IDX_W         = 5;
    localparam int FUNCT_W           = 6;

    function automatic bit depth_ok(int depth);
        return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/control/observation bundle of one pipeline register boundary.
// master drives the stage inputs, slave is the register itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              cnt_clr;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output stall, flush, cnt_clr, valid_in, ctrl_in, data_in,
        input  valid_out, ctrl_out, data_out, stall_cnt, flush_cnt
    );

    modport slave (
        input  stall, flush, cnt_clr, valid_in, ctrl_in, data_in,
        output valid_out, ctrl_out, data_out, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_cell.sv
// One pipeline register stage: load / hold / kill, with ctrl forced to zero
// whenever the stage holds a bubble.
module pipe_stage_cell #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              kill,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (kill) begin
            // data is left alone: it is don't-care once the stage is invalid
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load) begin
            valid_q <= valid_d;
            ctrl_q  <= valid_d ? ctrl_d : '0;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (DEPTH chained cells) with
// stall/flush control and saturating stall/flush event counters.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_reg_if.slave   bus
);
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH=%0d outside %0d..%0d", DEPTH, MIN_DEPTH, MAX_DEPTH);
    end

    logic [DEPTH-1:0]  valid_q;
    logic [CTRL_W-1:0] ctrl_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic              valid_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_d  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];

    logic load;
    assign load = !bus.stall;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign valid_d[g] = bus.valid_in;
            assign ctrl_d[g]  = bus.ctrl_in;
            assign data_d[g]  = bus.data_in;
        end else begin : g_chain
            assign valid_d[g] = valid_q[g-1];
            assign ctrl_d[g]  = ctrl_q[g-1];
            assign data_d[g]  = data_q[g-1];
        end

        pipe_stage_cell #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_cell (
            .clk     (clk),
            .reset   (reset),
            .load    (load),
            .kill    (bus.flush),
            .valid_d (valid_d[g]),
            .ctrl_d  (ctrl_d[g]),
            .data_d  (data_d[g]),
            .valid_q (valid_q[g]),
            .ctrl_q  (ctrl_q[g]),
            .data_q  (data_q[g])
        );
    end

    assign bus.valid_out = valid_q[DEPTH-1];
    assign bus.ctrl_out  = ctrl_q[DEPTH-1] & {CTRL_W{valid_q[DEPTH-1]}};
    assign bus.data_out  = data_q[DEPTH-1];

    // Event qualifiers look at pipeline state before the edge
    logic stall_ev, flush_ev;
    assign stall_ev = bus.stall && !bus.flush && valid_q[DEPTH-1];
    assign flush_ev = bus.flush && (|valid_q);

    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk) begin
        if (reset || bus.cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_ev && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: table-driven DEPTH=1 vectors, then hand sequences for
// DEPTH=3 latency/ordering and 4-bit counter saturation with mid-stall reset.
module tb_pipe_stage_reg;

    localparam logic [127:0] DA = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501;
    localparam logic [127:0] DB = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] DC = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    localparam logic [127:0] DD = 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall, flush, cnt_clr, valid_in;
    logic [15:0]  ctrl_in;
    logic [127:0] data_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(16), .CNT_W(16)) i1 ();
    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(16), .CNT_W(16)) i3 ();
    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(16), .CNT_W(4))  i4 ();

    assign i1.stall = stall;   assign i3.stall = stall;   assign i4.stall = stall;
    assign i1.flush = flush;   assign i3.flush = flush;   assign i4.flush = flush;
    assign i1.cnt_clr = cnt_clr; assign i3.cnt_clr = cnt_clr; assign i4.cnt_clr = cnt_clr;
    assign i1.valid_in = valid_in; assign i3.valid_in = valid_in; assign i4.valid_in = valid_in;
    assign i1.ctrl_in = ctrl_in; assign i3.ctrl_in = ctrl_in; assign i4.ctrl_in = ctrl_in;
    assign i1.data_in = data_in; assign i3.data_in = data_in; assign i4.data_in = data_in;

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .reset(reset), .bus(i1.slave));
    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .reset(reset), .bus(i3.slave));
    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .DEPTH(1), .CNT_W(4)) u_c4 (
        .clk(clk), .reset(reset), .bus(i4.slave));

    typedef struct {
        logic         st, fl, vi;
        logic [15:0]  ci;
        logic [127:0] di;
        logic         clr;
        logic         ev;
        logic [15:0]  ec;
        logic [127:0] ed;
        logic [15:0]  esc, efc;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic vi,
                         input logic [15:0] ci, input logic [127:0] di, input logic clr);
        stall = st; flush = fl; valid_in = vi; ctrl_in = ci; data_in = di; cnt_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] exp_d [8];
    logic [15:0]  exp_c [8];
    logic         exp_v [8];

    initial begin
        //        st fl vi ctrl_in   data_in clr  ev ec        ed  esc fc
        tv[0]  = '{0, 0, 1, 16'h0029, DA, 0,    1, 16'h0029, DA, 0, 0};
        tv[1]  = '{1, 0, 1, 16'h0008, DB, 0,    1, 16'h0029, DA, 1, 0};
        tv[2]  = '{1, 0, 1, 16'h0008, DB, 0,    1, 16'h0029, DA, 2, 0};
        tv[3]  = '{1, 0, 1, 16'h0008, DB, 0,    1, 16'h0029, DA, 3, 0};
        tv[4]  = '{0, 0, 1, 16'h0008, DB, 0,    1, 16'h0008, DB, 3, 0};
        tv[5]  = '{1, 1, 1, 16'h0020, DC, 0,    0, 16'h0000, DB, 3, 1};
        tv[6]  = '{0, 0, 0, 16'hFFFF, DD, 0,    0, 16'h0000, DD, 3, 1};
        tv[7]  = '{0, 1, 1, 16'h0001, DA, 0,    0, 16'h0000, DD, 3, 1};
        tv[8]  = '{1, 0, 1, 16'h0002, DA, 0,    0, 16'h0000, DD, 3, 1};
        tv[9]  = '{0, 0, 1, 16'h0029, DA, 0,    1, 16'h0029, DA, 3, 1};
        tv[10] = '{0, 0, 1, 16'h0020, DC, 1,    1, 16'h0020, DC, 0, 0};
        tv[11] = '{1, 0, 1, 16'h0008, DB, 1,    1, 16'h0020, DC, 0, 0};
        tv[12] = '{1, 0, 1, 16'h0008, DB, 0,    1, 16'h0020, DC, 1, 0};

        // Reset for 2 cycles while a valid item is presented
        reset = 1'b1;
        drive(0, 0, 1, 16'h0029, DA, 0);
        for (int r = 0; r < 2; r++) begin
            tick();
            chk($sformatf("rst%0d valid", r), 128'(i1.valid_out), 128'(1'b0));
            chk($sformatf("rst%0d ctrl", r),  128'(i1.ctrl_out), 128'h0);
            chk($sformatf("rst%0d data", r),  i1.data_out, 128'h0);
            chk($sformatf("rst%0d cnts", r),  128'({i1.stall_cnt, i1.flush_cnt}), 128'h0);
        end
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tv[i].st, tv[i].fl, tv[i].vi, tv[i].ci, tv[i].di, tv[i].clr);
            tick();
            chk($sformatf("vec%0d valid", i), 128'(i1.valid_out), 128'(tv[i].ev));
            chk($sformatf("vec%0d ctrl", i),  128'(i1.ctrl_out), 128'(tv[i].ec));
            chk($sformatf("vec%0d data", i),  i1.data_out, tv[i].ed);
            chk($sformatf("vec%0d stall_cnt", i), 128'(i1.stall_cnt), 128'(tv[i].esc));
            chk($sformatf("vec%0d flush_cnt", i), 128'(i1.flush_cnt), 128'(tv[i].efc));
        end

        // DEPTH=3: items 1,2,3 with a stall on the third presentation
        reset = 1'b1;
        drive(0, 0, 0, 16'h0, 128'h0, 0);
        tick();
        reset = 1'b0;
        exp_v = '{0, 0, 0, 1, 1, 1, 0, 0};
        exp_c = '{16'h0, 16'h0, 16'h0, 16'h0101, 16'h0202, 16'h0303, 16'h0, 16'h0};
        exp_d = '{128'h0, 128'h0, 128'h0, 128'h1, 128'h2, 128'h3, 128'h0, 128'h0};
        for (int e = 0; e < 7; e++) begin
            case (e)
                0: drive(0, 0, 1, 16'h0101, 128'h1, 0);
                1: drive(0, 0, 1, 16'h0202, 128'h2, 0);
                2: drive(1, 0, 1, 16'h0303, 128'h3, 0);
                3: drive(0, 0, 1, 16'h0303, 128'h3, 0);
                default: drive(0, 0, 0, 16'h0, 128'h0, 0);
            endcase
            tick();
            chk($sformatf("d3 e%0d valid", e + 1), 128'(i3.valid_out), 128'(exp_v[e]));
            chk($sformatf("d3 e%0d ctrl", e + 1),  128'(i3.ctrl_out), 128'(exp_c[e]));
            if (exp_v[e])
                chk($sformatf("d3 e%0d data", e + 1), i3.data_out, exp_d[e]);
        end
        chk("d3 stall_cnt", 128'(i3.stall_cnt), 128'h0);

        // Counter saturation at CNT_W=4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0, 1, 16'h0029, DA, 0);
        tick();
        drive(1, 0, 1, 16'h0008, DB, 0);
        for (int s = 0; s < 20; s++) begin
            tick();
            if (s == 14) chk("c4 stall_cnt at 15", 128'(i4.stall_cnt), 128'hF);
        end
        chk("c4 stall_cnt sat", 128'(i4.stall_cnt), 128'hF);
        chk("c4 data held", i4.data_out, DA);
        chk("d1 stall_cnt 20", 128'(i1.stall_cnt), 128'd20);
        cnt_clr = 1'b1;
        tick();
        chk("c4 cnt_clr", 128'(i4.stall_cnt), 128'h0);
        chk("c4 valid after clr", 128'(i4.valid_out), 128'(1'b1));
        cnt_clr = 1'b0;
        tick();
        chk("c4 stall_cnt restart", 128'(i4.stall_cnt), 128'h1);
        reset = 1'b1;
        tick();
        chk("c4 rst valid", 128'(i4.valid_out), 128'(1'b0));
        chk("c4 rst ctrl",  128'(i4.ctrl_out), 128'h0);
        chk("c4 rst data",  i4.data_out, 128'h0);
        chk("c4 rst cnts",  128'({i4.stall_cnt, i4.flush_cnt}), 128'h0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
